// File: rtl/lfsr_prog_if.sv
// -----------------------------------------------------------------------------
// lfsr_prog_if
// Control/status bundle of the programmable LFSR.
//   master : drives enable, load, data_in, taps_in, mode_xnor;
//            observes data_out, busy, done, period, overflow, lockup.
//   slave  : the LFSR itself (mirror image of master).
// -----------------------------------------------------------------------------
interface lfsr_prog_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                  enable;
  logic                  load;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] taps_in;
  logic                  mode_xnor;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  busy;
  logic                  done;
  logic [CNT_WIDTH-1:0]  period;
  logic                  overflow;
  logic                  lockup;

  modport master (
    output enable, load, data_in, taps_in, mode_xnor,
    input  data_out, busy, done, period, overflow, lockup
  );

  modport slave (
    input  enable, load, data_in, taps_in, mode_xnor,
    output data_out, busy, done, period, overflow, lockup
  );
endinterface

// File: rtl/lfsr_prog.sv
// -----------------------------------------------------------------------------
// lfsr_prog
// Runtime-programmable Fibonacci LFSR with period measurement.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : lfsr_prog_if.slave
//            enable    - clock enable, all state holds when low
//            load      - load seed/taps/mode (only while enable=1)
//            data_in   - seed,  taps_in - tap mask (bit i = stage i+1)
//            mode_xnor - 1: XNOR feedback, 0: XOR feedback
//            data_out  - current LFSR state
//            busy      - measurement running
//            done      - measurement finished (sticky until load/reset)
//            period    - measured period, valid with done
//            overflow  - counter saturated before the seed recurred
//            lockup    - loaded seed is the lock-up state for the mode
// After a load the LFSR shifts and counts until the post-shift state equals
// the seed again; the count at that point is the sequence period.
// -----------------------------------------------------------------------------
module lfsr_prog #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    CNT_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TAPS = DATA_WIDTH'(8'hB8)
) (
  input  logic       clk,
  input  logic       rst_n,
  lfsr_prog_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    LOCK = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] lfsr_q;
  logic [DATA_WIDTH-1:0] taps_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic                  mode_q;
  logic [CNT_WIDTH-1:0]  step_cnt_q;
  logic [CNT_WIDTH-1:0]  period_q;
  logic                  done_q;
  logic                  overflow_q;

  logic                  fb;
  logic [DATA_WIDTH-1:0] nxt;
  logic [CNT_WIDTH-1:0]  cnt_inc;
  logic                  seed_hit;
  logic                  cnt_sat;
  logic                  load_lock;
  logic                  busy;
  logic                  lockup;

  // Feedback/compare datapath shared by the FSM and the register block.
  assign fb        = (^(lfsr_q & taps_q)) ^ mode_q;
  assign nxt       = {lfsr_q[DATA_WIDTH-2:0], fb};
  assign cnt_inc   = step_cnt_q + CNT_WIDTH'(1);
  assign seed_hit  = (nxt == seed_q);
  assign cnt_sat   = (cnt_inc == CNT_MAX);
  // Lock-up is judged against the incoming mode, not the registered one.
  assign load_lock = bus.mode_xnor ? (&bus.data_in) : ~(|bus.data_in);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: asynchronous reset: the flop is cleared on the falling edge of
  // rst_n without waiting for clk, so outputs drop immediately mid-run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // flop samples pre-edge values regardless of statement order.
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    if (bus.enable) begin
      if (bus.load) begin
        state_d = load_lock ? LOCK : RUN;
      end else begin
        unique case (state_q)
          RUN:     if (seed_hit || cnt_sat) state_d = DONE;
          default: state_d = state_q;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    busy   = 1'b0;
    lockup = 1'b0;
    unique case (state_q)
      RUN:     busy   = 1'b1;
      LOCK:    lockup = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: shift register, configuration, counter, results
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q     <= '0;
      taps_q     <= DEFAULT_TAPS;
      seed_q     <= '0;
      mode_q     <= 1'b1;
      step_cnt_q <= '0;
      period_q   <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.enable) begin
      if (bus.load) begin
        // A load always wins, even on the edge that would finish a run.
        lfsr_q     <= bus.data_in;
        seed_q     <= bus.data_in;
        taps_q     <= bus.taps_in;
        mode_q     <= bus.mode_xnor;
        step_cnt_q <= '0;
        period_q   <= '0;
        done_q     <= 1'b0;
        overflow_q <= 1'b0;
      end else begin
        unique case (state_q)
          RUN: begin
            lfsr_q     <= nxt;
            step_cnt_q <= cnt_inc;
            // Seed match has priority, so a match on the saturating count
            // still reports a clean period.
            if (seed_hit) begin
              period_q <= cnt_inc;
              done_q   <= 1'b1;
            end else if (cnt_sat) begin
              period_q   <= CNT_MAX;
              overflow_q <= 1'b1;
              done_q     <= 1'b1;
            end
          end
          LOCK:    ;
          default: lfsr_q <= nxt;
        endcase
      end
    end
  end

  assign bus.data_out = lfsr_q;
  assign bus.busy     = busy;
  assign bus.done     = done_q;
  assign bus.period   = period_q;
  assign bus.overflow = overflow_q;
  assign bus.lockup   = lockup;

endmodule

// File: tb/tb_lfsr_prog.sv
// -----------------------------------------------------------------------------
// tb_lfsr_prog
// Four lfsr_prog instances of different widths share one stimulus stream.
// A behavioural model (plain arithmetic on 32-bit words) tracks every
// instance and is compared after each clock edge and each reset assertion;
// directed sequences additionally check hand-derived constants.
//   idx 0: DATA_WIDTH=8 CNT_WIDTH=8
//   idx 1: DATA_WIDTH=4 CNT_WIDTH=4
//   idx 2: DATA_WIDTH=5 CNT_WIDTH=3
//   idx 3: DATA_WIDTH=5 CNT_WIDTH=8
// -----------------------------------------------------------------------------
module tb_lfsr_prog;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        mode_xnor = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] taps_in = '0;

  always #5 clk = ~clk;

  lfsr_prog_if #(.DATA_WIDTH(8), .CNT_WIDTH(8)) if_a ();
  lfsr_prog_if #(.DATA_WIDTH(4), .CNT_WIDTH(4)) if_b ();
  lfsr_prog_if #(.DATA_WIDTH(5), .CNT_WIDTH(3)) if_c ();
  lfsr_prog_if #(.DATA_WIDTH(5), .CNT_WIDTH(8)) if_d ();

  assign if_a.enable = enable;  assign if_a.load = load;  assign if_a.mode_xnor = mode_xnor;
  assign if_a.data_in = data_in[7:0];  assign if_a.taps_in = taps_in[7:0];
  assign if_b.enable = enable;  assign if_b.load = load;  assign if_b.mode_xnor = mode_xnor;
  assign if_b.data_in = data_in[3:0];  assign if_b.taps_in = taps_in[3:0];
  assign if_c.enable = enable;  assign if_c.load = load;  assign if_c.mode_xnor = mode_xnor;
  assign if_c.data_in = data_in[4:0];  assign if_c.taps_in = taps_in[4:0];
  assign if_d.enable = enable;  assign if_d.load = load;  assign if_d.mode_xnor = mode_xnor;
  assign if_d.data_in = data_in[4:0];  assign if_d.taps_in = taps_in[4:0];

  lfsr_prog #(.DATA_WIDTH(8), .CNT_WIDTH(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  lfsr_prog #(.DATA_WIDTH(4), .CNT_WIDTH(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  lfsr_prog #(.DATA_WIDTH(5), .CNT_WIDTH(3)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));
  lfsr_prog #(.DATA_WIDTH(5), .CNT_WIDTH(8)) u_d (.clk(clk), .rst_n(rst_n), .bus(if_d.slave));

  // Observed outputs, zero-extended to 32 bits.
  logic [31:0] o_data [N];
  logic [31:0] o_period [N];
  logic        o_busy [N];
  logic        o_done [N];
  logic        o_ovf [N];
  logic        o_lock [N];

  assign o_data[0] = 32'(if_a.data_out);  assign o_period[0] = 32'(if_a.period);
  assign o_data[1] = 32'(if_b.data_out);  assign o_period[1] = 32'(if_b.period);
  assign o_data[2] = 32'(if_c.data_out);  assign o_period[2] = 32'(if_c.period);
  assign o_data[3] = 32'(if_d.data_out);  assign o_period[3] = 32'(if_d.period);
  assign o_busy[0] = if_a.busy;  assign o_done[0] = if_a.done;  assign o_ovf[0] = if_a.overflow;  assign o_lock[0] = if_a.lockup;
  assign o_busy[1] = if_b.busy;  assign o_done[1] = if_b.done;  assign o_ovf[1] = if_b.overflow;  assign o_lock[1] = if_b.lockup;
  assign o_busy[2] = if_c.busy;  assign o_done[2] = if_c.done;  assign o_ovf[2] = if_c.overflow;  assign o_lock[2] = if_c.lockup;
  assign o_busy[3] = if_d.busy;  assign o_done[3] = if_d.done;  assign o_ovf[3] = if_d.overflow;  assign o_lock[3] = if_d.lockup;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference model
  // ---------------------------------------------------------------------------
  function automatic int dw(input int i);
    case (i)
      0:       return 8;
      1:       return 4;
      default: return 5;
    endcase
  endfunction

  function automatic int cw(input int i);
    case (i)
      1:       return 4;
      2:       return 3;
      default: return 8;
    endcase
  endfunction

  function automatic logic [31:0] mask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  logic [31:0] m_lf [N];
  logic [31:0] m_tp [N];
  logic [31:0] m_seed [N];
  logic [31:0] m_cnt [N];
  logic [31:0] m_per [N];
  bit          m_md [N];
  bit          m_meas [N];
  bit          m_lock [N];
  bit          m_done [N];
  bit          m_ovf [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_lf[i]   = '0;
      m_tp[i]   = 32'hB8 & mask(dw(i));
      m_seed[i] = '0;
      m_cnt[i]  = '0;
      m_per[i]  = '0;
      m_md[i]   = 1'b1;
      m_meas[i] = 1'b0;
      m_lock[i] = 1'b0;
      m_done[i] = 1'b0;
      m_ovf[i]  = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      logic [31:0] m, cm, seed, nx;
      m  = mask(dw(i));
      cm = mask(cw(i));
      if (load) begin
        seed      = data_in & m;
        m_lf[i]   = seed;
        m_seed[i] = seed;
        m_tp[i]   = taps_in & m;
        m_md[i]   = mode_xnor;
        m_cnt[i]  = '0;
        m_per[i]  = '0;
        m_done[i] = 1'b0;
        m_ovf[i]  = 1'b0;
        m_lock[i] = mode_xnor ? (seed == m) : (seed == 32'd0);
        m_meas[i] = !m_lock[i];
      end else if (!m_lock[i]) begin
        // New bit = parity of tapped stages, plus one when XNOR.
        nx = ((m_lf[i] << 1) | 32'(($countones(m_lf[i] & m_tp[i]) + int'(m_md[i])) % 2)) & m;
        m_lf[i] = nx;
        if (m_meas[i]) begin
          m_cnt[i] = m_cnt[i] + 1;
          if (nx == m_seed[i]) begin
            m_per[i]  = m_cnt[i];
            m_done[i] = 1'b1;
            m_meas[i] = 1'b0;
          end else if (m_cnt[i] == cm) begin
            m_per[i]  = cm;
            m_ovf[i]  = 1'b1;
            m_done[i] = 1'b1;
            m_meas[i] = 1'b0;
          end
        end
      end
    end
  endtask

  // Model advances on each active edge / reset assertion, DUTs checked 1 ns later.
  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n)      model_reset();
    else if (enable) model_step();
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("d%0d_data", i),     o_data[i],        m_lf[i]);
      check($sformatf("d%0d_busy", i),     32'(o_busy[i]),   32'(m_meas[i]));
      check($sformatf("d%0d_done", i),     32'(o_done[i]),   32'(m_done[i]));
      check($sformatf("d%0d_period", i),   o_period[i],      m_per[i]);
      check($sformatf("d%0d_overflow", i), 32'(o_ovf[i]),    32'(m_ovf[i]));
      check($sformatf("d%0d_lockup", i),   32'(o_lock[i]),   32'(m_lock[i]));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus (always entered/left at a falling clock edge)
  // ---------------------------------------------------------------------------
  task automatic do_load(input logic [31:0] seed, input logic [31:0] taps, input logic mx);
    load      = 1'b1;
    data_in   = seed;
    taps_in   = taps;
    mode_xnor = mx;
    @(negedge clk);
    load = 1'b0;
  endtask

  logic [31:0] exp_seq [5];

  initial begin
    exp_seq = '{32'h1, 32'h2, 32'h4, 32'h9, 32'h3};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_data", o_data[0], 32'h0);
    check("rst_done", 32'(o_done[0]), 32'h0);
    enable = 1'b1;

    // 5-bit XNOR x^5+x^3+1 from seed 0: period 31 (idx 3), overflow at 7 (idx 2).
    do_load(32'h0, 32'h14, 1'b1);
    check("t1_load_busy", 32'(o_busy[3]), 32'h1);
    for (int e = 1; e <= 31; e++) begin
      @(negedge clk);
      if (e < 31) check("t1_busy", 32'(o_busy[3]), 32'h1);
      if (e == 6) check("ovf_done_early", 32'(o_done[2]), 32'h0);
      if (e == 7) begin
        check("ovf_done", 32'(o_done[2]), 32'h1);
        check("ovf_flag", 32'(o_ovf[2]), 32'h1);
        check("ovf_period", o_period[2], 32'h7);
      end
    end
    check("t1_done", 32'(o_done[3]), 32'h1);
    check("t1_period", o_period[3], 32'd31);
    check("t1_data", o_data[3], 32'h0);
    check("t1_ovf", 32'(o_ovf[3]), 32'h0);
    check("t1_busy_fall", 32'(o_busy[3]), 32'h0);

    // 4-bit XOR taps 1100: sequence check, period 15 lands on saturation (idx 1).
    do_load(32'h1, 32'hC, 1'b0);
    check("t2_seq0", o_data[1], exp_seq[0]);
    for (int e = 1; e <= 15; e++) begin
      @(negedge clk);
      if (e <= 4) check($sformatf("t2_seq%0d", e), o_data[1], exp_seq[e]);
      if (e == 14) check("t2_done_early", 32'(o_done[1]), 32'h0);
    end
    check("t2_done", 32'(o_done[1]), 32'h1);
    check("t2_period", o_period[1], 32'd15);
    check("t2_tie_ovf", 32'(o_ovf[1]), 32'h0);

    // Rotation, period 4, with enable low for three cycles mid-run.
    do_load(32'h1, 32'h8, 1'b0);
    for (int e = 1; e <= 7; e++) begin
      enable = !(e >= 3 && e <= 5);
      @(negedge clk);
      check($sformatf("t3_done_e%0d", e), 32'(o_done[1]), (e == 7) ? 32'h1 : 32'h0);
    end
    enable = 1'b1;
    check("t3_period", o_period[1], 32'd4);

    // Load colliding with completion: load wins.
    do_load(32'h1, 32'h8, 1'b0);
    repeat (3) @(negedge clk);
    do_load(32'h1, 32'h8, 1'b0);
    check("coll_done", 32'(o_done[1]), 32'h0);
    check("coll_busy", 32'(o_busy[1]), 32'h1);

    // Lock-up seeds.
    do_load(32'h0, 32'hC, 1'b0);
    check("lk_xor", 32'(o_lock[1]), 32'h1);
    repeat (20) begin
      @(negedge clk);
      check("lk_hold_data", o_data[1], 32'h0);
      check("lk_hold_done", 32'(o_done[1]), 32'h0);
    end
    do_load(32'hFFFF_FFFF, 32'hC, 1'b1);
    check("lk_xnor", 32'(o_lock[1]), 32'h1);
    check("lk_xnor_data", o_data[1], 32'hF);
    do_load(32'h5, 32'hC, 1'b0);
    check("lk_exit", 32'(o_lock[1]), 32'h0);
    check("lk_exit_busy", 32'(o_busy[1]), 32'h1);

    // Tap mask 0 on 8 bits: seed never recurs, saturates at 255.
    do_load(32'h81, 32'h0, 1'b0);
    for (int e = 1; e <= 255; e++) begin
      @(negedge clk);
      if (e == 254) check("t0_done_early", 32'(o_done[0]), 32'h0);
    end
    check("t0_done", 32'(o_done[0]), 32'h1);
    check("t0_ovf", 32'(o_ovf[0]), 32'h1);
    check("t0_period", o_period[0], 32'hFF);

    // Asynchronous reset mid-run, then XNOR free-run from 0 with default taps.
    do_load(32'h5A, 32'hB8, 1'b1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("ar%0d_data", i), o_data[i], 32'h0);
      check($sformatf("ar%0d_busy", i), 32'(o_busy[i]), 32'h0);
      check($sformatf("ar%0d_period", i), o_period[i], 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("free_run_a", o_data[0], 32'h01);
    check("free_run_d", o_data[3], 32'h01);

    // Randomised traffic, checked every edge by the model.
    repeat (2500) begin
      @(negedge clk);
      enable    = ($urandom_range(0, 99) < 85);
      load      = ($urandom_range(0, 99) < 2);
      mode_xnor = 1'($urandom_range(0, 1));
      taps_in   = $urandom;
      case ($urandom_range(0, 9))
        0:       data_in = 32'h0;
        1:       data_in = 32'hFFFF_FFFF;
        default: data_in = $urandom;
      endcase
    end
    load   = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_prog.md
# lfsr_prog

Runtime-programmable Fibonacci LFSR, the parametrised successor to the fixed-polynomial XNOR LFSR. Tap mask and XOR/XNOR mode are loaded at run time rather than chosen by width. Measures the sequence period by counting shifts until the seed recurs, and flags lock-up seeds. Used as a pseudo-random source and as a self-checking polynomial characteriser.

## Interface
- DATA_WIDTH, 8: LFSR width; legal range 2..32.
- CNT_WIDTH, 8: period counter width; legal range 1..32.
- DEFAULT_TAPS, 8'hB8: tap mask after reset. Bit i set means stage i+1 is tapped.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  clock enable; all state holds when low.
- load  in  1  load seed/taps/mode; acts only when enable=1.
- data_in  in  DATA_WIDTH  seed.
- taps_in  in  DATA_WIDTH  tap mask, sampled on load.
- mode_xnor  in  1  1 = XNOR feedback, 0 = XOR; sampled on load.
- data_out  out  DATA_WIDTH  current LFSR state.
- busy  out  1  period measurement in progress (state RUN).
- done  out  1  measurement finished; sticky until next load or reset.
- period  out  CNT_WIDTH  measured period; valid when done=1.
- overflow  out  1  counter saturated before the seed recurred.
- lockup  out  1  loaded seed is the lock-up state for the selected mode.

## Operation
- Feedback: fb = ^(lfsr & taps). Invert fb when mode_xnor=1. Shift: lfsr <= {lfsr[DATA_WIDTH-2:0], fb}.
- Lock-up state: all-zeros for XOR, all-ones for XNOR.
- Reset values: lfsr=0, taps=DEFAULT_TAPS, mode=XNOR, state IDLE, step_cnt=0, and busy/done/period/overflow/lockup all 0.
- States: IDLE, RUN, DONE, LOCK. Every transition requires enable=1.
- Any state, load=1:
  - lfsr <= data_in; seed_reg <= data_in; taps/mode registers updated; step_cnt <= 0.
  - done, overflow and period cleared.
  - Go to LOCK if data_in is the lock-up state for mode_xnor, otherwise to RUN.
  - load takes priority over shifting.
- IDLE: free-running shift with the current taps/mode; no counting.
- RUN: shift and step_cnt++ each enabled cycle. Let nxt be the post-shift state.
  - nxt == seed_reg: period <= step_cnt+1, done <= 1, go to DONE.
  - Else if step_cnt+1 == 2^CNT_WIDTH-1: period <= all-ones, overflow <= 1, done <= 1, go to DONE.
  - If both conditions hold on the same edge, the match wins and overflow stays 0.
- DONE: free-running shift continues; done, period and overflow held.
- LOCK: lockup=1; lfsr holds (no shift); done=0. Exit only via load or reset.
- Tap mask 0: feedback is constant, so the seed normally never recurs and the run ends in overflow.
- busy = (state == RUN); lockup = (state == LOCK).

## Timing
- Load on edge k: data_out = data_in after edge k; first shift on edge k+1.
- For period P ≤ 2^CNT_WIDTH-1 with enable held high: done and period update on edge k+P, the same edge on which data_out returns to the seed. busy falls on that edge.
- enable low for n cycles stretches every latency by n; no events are lost.
- done, period and overflow are registered outputs.
- rst_n assertion is asynchronous: all outputs take reset values immediately, including mid-RUN. Release is synchronised by the integrator.
- load on the same edge that would complete a measurement: load wins; done stays 0.

## Test plan
- DATA_WIDTH=5, taps 5'b10100, XNOR, seed 0, enable continuous, CNT_WIDTH=8 -> busy high 31 cycles; done=1 with period=31 on edge 31 after load; data_out=0 on that edge; overflow=0.
- DATA_WIDTH=4, taps 4'b1100, XOR, seed 4'b0001 -> data_out sequence 0001, 0010, 0100, 1001, 0011; period=15.
- DATA_WIDTH=4, taps 4'b1000, XOR, seed 4'b0001 -> rotation; period=4. Toggle enable low 3 cycles mid-run -> done arrives 3 cycles later; period still 4.
- Lock-up, DATA_WIDTH=4: XOR with seed 0 -> lockup=1, data_out stays 0 for 20 cycles, done=0. Then load XNOR with seed 4'b1111 -> lockup=1. Then load a valid seed -> lockup=0, busy=1.
- CNT_WIDTH=3, DATA_WIDTH=5, maximal taps -> done with overflow=1 and period=3'b111 on edge 7 after load.
- Assert rst_n mid-RUN -> all outputs 0 immediately. After release, XNOR free-run from 0 with DEFAULT_TAPS: data_out=8'h01 on the first enabled edge.
